inst_rom_arbiter: RTL and testbench

- Shares the single combinational instruction ROM port between two requesters:
  - M0: the IF-stage fetch.
  - M1: the MEM-stage read of the text region, used for constant pools and self-inspection loads.
- Fixed priority to M1, with a starvation guard for M0.
- One-cycle registered read latency, per-requester valid/error responses, and a stall output for the IF stage.
- Sits between pc_reg/if_id and mem on one side and the instruction ROM on the other.

---
 rtl/inst_rom_arbiter.sv | 147 ++++++++++++++
 tb/tb_inst_rom_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_arbiter.sv
// Arbitrates the single instruction ROM port between IF fetch (M0) and MEM text reads (M1).
// Optional performance counters are compiled in when INST_ROM_ARB_PERF_EN is defined.
module inst_rom_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_flush,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    output logic              if_stall,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
`ifdef INST_ROM_ARB_PERF_EN
    output logic [CNT_W-1:0]  perf_conflict,
    output logic [CNT_W-1:0]  perf_force,
`endif
    input  logic [DATA_W-1:0] rom_inst
);

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RESP_M0 = 2'd1;
    localparam logic [1:0] RESP_M1 = 2'd2;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [1:0]        resp_state_reg, resp_state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic [DATA_W-1:0] m0_rdata_reg, m1_rdata_reg;
    logic              m0_err_reg, m1_err_reg;

    logic              force_m0;
    logic              gnt_any;
    logic [ADDR_W-1:0] gnt_addr;
    logic              misaligned;
    logic [DATA_W-1:0] capture_data;

    assign force_m0 = (wait_cnt_reg == MAX_WAIT_C);

    // Grants are suppressed while reset is held so the ROM sees no access.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst) begin
            if (force_m0 && m0_req)
                m0_gnt = 1'b1;
            else if (m1_req)
                m1_gnt = 1'b1;
            else if (m0_req)
                m0_gnt = 1'b1;
        end
    end

    assign gnt_any      = m0_gnt | m1_gnt;
    assign gnt_addr     = m0_gnt ? m0_addr : m1_addr;
    assign misaligned   = (gnt_addr[1:0] != 2'b00);
    assign capture_data = misaligned ? '0 : rom_inst;

    assign rom_ce   = (gnt_any && !misaligned) ? CHIP_ENABLE : CHIP_DISABLE;
    assign rom_addr = (gnt_any && !misaligned) ? gnt_addr : '0;
    assign if_stall = m0_req & ~m0_gnt;

    // A flushed M0 grant produces no response, so the FSM simply stays idle.
    always_comb begin
        resp_state_next = IDLE;
        if (m0_gnt && !m0_flush)
            resp_state_next = RESP_M0;
        else if (m1_gnt)
            resp_state_next = RESP_M1;
    end

    always_comb begin
        wait_cnt_next = '0;
        if (m0_req && !m0_gnt)
            wait_cnt_next = force_m0 ? wait_cnt_reg : wait_cnt_reg + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_state_reg <= IDLE;
            wait_cnt_reg   <= '0;
            m0_rdata_reg   <= '0;
            m0_err_reg     <= 1'b0;
            m1_rdata_reg   <= '0;
            m1_err_reg     <= 1'b0;
        end else begin
            resp_state_reg <= resp_state_next;
            wait_cnt_reg   <= wait_cnt_next;
            if (m0_gnt && !m0_flush) begin
                m0_rdata_reg <= capture_data;
                m0_err_reg   <= misaligned;
            end
            if (m1_gnt) begin
                m1_rdata_reg <= capture_data;
                m1_err_reg   <= misaligned;
            end
        end
    end

    // A flush arriving in the response cycle masks the M0 response.
    assign m0_rvalid = (resp_state_reg == RESP_M0) & ~m0_flush;
    assign m1_rvalid = (resp_state_reg == RESP_M1);
    assign m0_rdata  = m0_rdata_reg;
    assign m0_err    = m0_err_reg;
    assign m1_rdata  = m1_rdata_reg;
    assign m1_err    = m1_err_reg;

`ifdef INST_ROM_ARB_PERF_EN
    logic [CNT_W-1:0] perf_conflict_reg, perf_force_reg;
    logic             conflict_hit, force_hit;

    assign conflict_hit = m0_req & m1_req;
    assign force_hit    = force_m0 & m0_req & m1_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict_reg <= '0;
            perf_force_reg    <= '0;
        end else begin
            if (conflict_hit && perf_conflict_reg != '1)
                perf_conflict_reg <= perf_conflict_reg + 1'b1;
            if (force_hit && perf_force_reg != '1)
                perf_force_reg <= perf_force_reg + 1'b1;
        end
    end

    assign perf_conflict = perf_conflict_reg;
    assign perf_force    = perf_force_reg;
`endif

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Randomized bench for inst_rom_arbiter with a cycle-level reference model of grants and responses.
module tb_inst_rom_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_flush = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic        m0_gnt, m0_rvalid, m0_err, if_stall;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata, rom_addr, rom_inst;
    logic        rom_ce;
`ifdef INST_ROM_ARB_PERF_EN
    logic [CNT_W-1:0] perf_conflict, perf_force;
`endif

    logic [31:0] rom_mem [64];
    assign rom_inst = rom_mem[rom_addr[7:2]];

    inst_rom_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_flush(m0_flush),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .if_stall(if_stall),
        .m1_req(m1_req), .m1_addr(m1_addr),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .rom_ce(rom_ce), .rom_addr(rom_addr),
`ifdef INST_ROM_ARB_PERF_EN
        .perf_conflict(perf_conflict), .perf_force(perf_force),
`endif
        .rom_inst(rom_inst)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: consecutive M0 denials, owner of the pending response, held read data.
    int          denials = 0;
    int          pend    = 0;
    logic [31:0] exp_d0 = '0, exp_d1 = '0;
    logic        exp_e0 = 1'b0, exp_e1 = 1'b0;
    logic        last_g0 = 1'b0;
    int          exp_conf = 0, exp_force = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a[1:0] != 2'b00) ? 32'h0 : rom_mem[a[7:2]];
    endfunction

    task automatic model_reset();
        denials = 0; pend = 0;
        exp_d0 = '0; exp_d1 = '0; exp_e0 = 1'b0; exp_e1 = 1'b0;
        exp_conf = 0; exp_force = 0; last_g0 = 1'b0;
    endtask

    task automatic step(input logic r0, input logic [31:0] a0, input logic f0,
                        input logic r1, input logic [31:0] a1);
        logic        forced, g0, g1, ok;
        logic [31:0] ga;
        @(negedge clk);
        m0_req = r0; m0_addr = a0; m0_flush = f0; m1_req = r1; m1_addr = a1;
        #1;
        forced = (denials >= MAX_WAIT);
        g0 = r0 && (forced || !r1);
        g1 = r1 && !g0;
        ga = g0 ? a0 : a1;
        ok = (g0 || g1) && (ga[1:0] == 2'b00);
        chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, g0});
        chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, g1});
        chk("if_stall", {31'b0, if_stall}, {31'b0, r0 && !g0});
        chk("rom_ce", {31'b0, rom_ce}, {31'b0, ok});
        chk("rom_addr", rom_addr, ok ? ga : 32'h0);
        chk("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, (pend == 1) && !f0});
        chk("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, pend == 2});
        chk("m0_rdata", m0_rdata, exp_d0);
        chk("m0_err", {31'b0, m0_err}, {31'b0, exp_e0});
        chk("m1_rdata", m1_rdata, exp_d1);
        chk("m1_err", {31'b0, m1_err}, {31'b0, exp_e1});
`ifdef INST_ROM_ARB_PERF_EN
        chk("perf_conflict", 32'(perf_conflict), 32'(exp_conf));
        chk("perf_force", 32'(perf_force), 32'(exp_force));
        if (r0 && r1) exp_conf++;
        if (r0 && r1 && forced) exp_force++;
`endif
        pend = 0;
        if (g0) begin
            denials = 0;
            if (!f0) begin
                pend = 1; exp_d0 = word_at(a0); exp_e0 = (a0[1:0] != 2'b00);
            end
        end else if (r0) begin
            denials = (denials < MAX_WAIT) ? denials + 1 : denials;
        end else begin
            denials = 0;
        end
        if (g1) begin
            pend = 2; exp_d1 = word_at(a1); exp_e1 = (a1[1:0] != 2'b00);
        end
        last_g0 = g0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom & 32'h0300_00FF;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        logic        r0, r1, f0;
        logic [31:0] a0, a1;
        for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;

        // Reset state, with requests present to confirm grants are held off.
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h8; m1_addr = 32'h4;
        #2;
        chk("rst_m0_gnt", {31'b0, m0_gnt}, 32'h0);
        chk("rst_m1_gnt", {31'b0, m1_gnt}, 32'h0);
        chk("rst_rom_ce", {31'b0, rom_ce}, 32'h0);
        chk("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
        chk("rst_m1_rvalid", {31'b0, m1_rvalid}, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk); rst = 1'b1;

        // Directed: single fetch, conflict, misaligned, both flush positions.
        step(1, 32'h8, 0, 0, 32'h0);
        step(0, 32'h0, 0, 0, 32'h0);
        step(1, 32'h0, 0, 1, 32'h4);
        step(1, 32'h0, 0, 0, 32'h0);
        step(0, 32'h0, 0, 1, 32'h6);
        step(0, 32'h0, 0, 0, 32'h0);
        step(1, 32'hC, 1, 0, 32'h0);
        step(0, 32'h0, 0, 0, 32'h0);
        step(1, 32'hC, 0, 0, 32'h0);
        step(0, 32'h0, 1, 0, 32'h0);
        step(0, 32'h0, 0, 0, 32'h0);

        // Starvation: continuous pressure from both sides.
        for (int i = 0; i < 15; i++) step(1, 32'h10, 0, 1, 32'h20);
        step(0, 32'h0, 0, 0, 32'h0);

        // Asynchronous reset while an M0 response is on the outputs.
        step(1, 32'h14, 0, 0, 32'h0);
        @(posedge clk); #2;
        chk("pre_rst_m0_rvalid", {31'b0, m0_rvalid}, 32'h1);
        rst = 1'b0;
        #1;
        chk("async_m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
        chk("async_m1_rvalid", {31'b0, m1_rvalid}, 32'h0);
        chk("async_rom_ce", {31'b0, rom_ce}, 32'h0);
        chk("async_m0_gnt", {31'b0, m0_gnt}, 32'h0);
        chk("async_m0_rdata", m0_rdata, 32'h0);
        m0_req = 1'b0;
        model_reset();
        @(negedge clk); rst = 1'b1;
        step(0, 32'h0, 0, 0, 32'h0);
        step(0, 32'h0, 0, 0, 32'h0);

        // Random traffic; a denied request keeps its address until granted.
        r0 = 1'b0; r1 = 1'b0; a0 = '0; a1 = '0;
        for (int i = 0; i < 600; i++) begin
            logic held0, held1;
            held0 = r0 && !last_g0;
            held1 = r1 && !(m1_gnt === 1'b1);
            if (!held0) begin r0 = ($urandom_range(0, 3) != 0); a0 = rnd_addr(); end
            if (!held1) begin r1 = ($urandom_range(0, 2) != 0); a1 = rnd_addr(); end
            f0 = ($urandom_range(0, 7) == 0);
            step(r0, a0, f0, r1, a1);
        end
        step(0, 32'h0, 0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
